seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
- Receive-side counterpart to the two-digit multiplexed 7-segment display driver.
- Samples the active-low digit-select and segment buses that the driver produces, and decodes each digit's segment pattern back to BCD.
- Assembles complete two-digit frames into a binary value 0..99.
- Used for on-board loopback self-check of the display path and as a scoreboard monitor in simulation.

Parameters:
STABLE_CYCLES, 16, consecutive identical samples within one digit phase required before that digit is captured
TIMEOUT_CYCLES, 4096, cycles without a fresh frame before valid drops

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst  input  1  synchronous, active-high reset
seg  input  4  digit selects, active-low; seg[0]=ones, seg[1]=tens, seg[3:2] must stay high
segments  input  8  segment lines, active-low; [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g [7]=dp (ignored)
ones  output  4  last framed ones digit, BCD
tens  output  4  last framed tens digit, BCD
value  output  7  tens*10+ones
valid  output  1  high while the last frame is younger than TIMEOUT_CYCLES
frame_strobe  output  1  one-cycle pulse when ones/tens/value update
err  output  1  one-cycle pulse on any protocol or decode error

Behaviour:
- Reset values: ones=0, tens=0, value=0, valid=0, frame_strobe=0, err=0. The FSM enters EMPTY and all counters clear. Reset wins over every simultaneous event, including reset asserted mid-frame.
- Input sampling:
  - seg and segments pass through two register stages before use.
  - Total latency is 2 sync cycles plus STABLE_CYCLES, plus 1 cycle to register outputs.
- Phase classification, on the synced sample:
  - ONES: seg=4'b1110.
  - TENS: seg=4'b1101.
  - GAP: seg=4'b1111.
  - ILLEGAL: anything else.
  - ILLEGAL pulses err once on entry and discards any partial capture of the current phase. The FSM state is kept.
- Stability counter:
  - Resets to 0 whenever the phase changes or the segment pattern (bits 6:0) differs from the previous sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - A capture fires exactly once per phase visit, on the cycle the count reaches STABLE_CYCLES.
  - A phase visit shorter than STABLE_CYCLES produces no capture and no error.
- Decode of lit = ~segments[6:0], listed as g..a (bit 6 down to bit 0):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - All-dark (0000000) decodes as 0 (blank-leading-zero tolerance).
  - Any other pattern pulses err, and that capture is discarded.
- Frame FSM:
  - EMPTY: ones capture -> HAVE_ONES (hold ones_tmp); tens capture -> HAVE_TENS (hold tens_tmp).
  - HAVE_ONES: tens capture -> emit, back to EMPTY. Ones capture -> overwrite ones_tmp, stay.
  - HAVE_TENS: ones capture -> emit, back to EMPTY. Tens capture -> overwrite tens_tmp, stay.
  - Emit (registered, next cycle):
    - ones and tens are loaded.
    - value = tens*10+ones, computed in 7 bits; the max of 99 fits.
    - frame_strobe pulses for 1 cycle, valid is set, and the timeout counter clears.
  - A decode error during HAVE_x returns the FSM to EMPTY.
- Timeout:
  - The counter increments every cycle while valid=1, and clears on emit.
  - When it reaches TIMEOUT_CYCLES, valid drops. Outputs hold their last values.
- err and frame_strobe may assert in the same cycle only if they come from different events. They never assert for the same capture.

Test Plan:
- Driver-style scan of 23: alternate 512 cycles ONES (lit 1001111) and 512 cycles TENS (lit 1011011) -> first frame_strobe about STABLE_CYCLES+3 cycles into the second phase; ones=3, tens=2, value=23, valid=1, err never pulses.
- Sweep 0..31, then 99: scan each value for two full periods -> value matches on every frame_strobe. Tens blanked (all-dark) with ones=7 -> value=7.
- Glitch: a 5-cycle pattern change inside a ONES phase, then the original pattern -> no spurious capture; decoded digit is unchanged once stable.
- Illegal: seg=4'b1100 for 20 cycles -> err pulses exactly once. Ones pattern 0110000 held stable -> err pulse and FSM returns to EMPTY.
- Timeout: a valid frame of 42, then seg held at 4'b1111 -> valid falls exactly TIMEOUT_CYCLES cycles after the strobe; value stays 42.
- Reset mid-frame: assert sys_rst while in HAVE_ONES -> all outputs 0 next cycle. The next complete scan of 15 yields value=15 with no leftover ones_tmp.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module : seven_seg_scan_decoder
// Desc   : Samples a two-digit multiplexed active-low 7-segment bus and
//          reassembles complete frames into BCD digits and a 0..99 value.
// Rev    : 1.0  initial release
// ============================================================================
module seven_seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] seg,
  input  logic [7:0] segments,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] value,
  output logic       valid,
  output logic       frame_strobe,
  output logic       err
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SCW-1:0] STABLE_FULL = SCW'(STABLE_CYCLES);
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_END = TCW'(TIMEOUT_CYCLES);

  localparam logic [1:0] PH_GAP     = 2'd0;
  localparam logic [1:0] PH_ONES    = 2'd1;
  localparam logic [1:0] PH_TENS    = 2'd2;
  localparam logic [1:0] PH_ILLEGAL = 2'd3;

  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_HAVE_ONES = 2'd1;
  localparam logic [1:0] ST_HAVE_TENS = 2'd2;

  // Decimal point carries no digit information.
  logic unused_dp;
  assign unused_dp = segments[7];

  logic [3:0]     seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [6:0]     pat_s1_q, pat_s1_d, pat_s2_q, pat_s2_d;
  logic [1:0]     prev_phase_q, prev_phase_d;
  logic [6:0]     prev_pat_q, prev_pat_d;
  logic [SCW-1:0] stab_cnt_q, stab_cnt_d;
  logic           done_q, done_d;
  logic [1:0]     state_q, state_d;
  logic [3:0]     tmp_q, tmp_d;
  logic [3:0]     ones_q, ones_d, tens_q, tens_d;
  logic [6:0]     value_q, value_d;
  logic           valid_q, valid_d;
  logic           strobe_q, strobe_d;
  logic           err_q, err_d;
  logic [TCW-1:0] tout_q, tout_d;

  logic [1:0] phase;
  logic       same;
  logic       capture;
  logic       illegal_entry;
  logic [6:0] lit;
  logic       dec_ok;
  logic [3:0] dec_digit;
  logic       emit;
  logic [3:0] new_ones, new_tens;

  always_comb begin
    seg_s1_d = seg;
    seg_s2_d = seg_s1_q;
    pat_s1_d = segments[6:0];
    pat_s2_d = pat_s1_q;

    case (seg_s2_q)
      4'b1110: phase = PH_ONES;
      4'b1101: phase = PH_TENS;
      4'b1111: phase = PH_GAP;
      default: phase = PH_ILLEGAL;
    endcase

    prev_phase_d = phase;
    prev_pat_d   = pat_s2_q;

    same = (phase == prev_phase_q) && (pat_s2_q == prev_pat_q);
    if (!same)
      stab_cnt_d = '0;
    else if (stab_cnt_q == STABLE_FULL)
      stab_cnt_d = stab_cnt_q;
    else
      stab_cnt_d = stab_cnt_q + SCW'(1);

    // One capture per phase visit; a glitch that settles back does not re-fire.
    capture = same && (stab_cnt_q == STABLE_LAST) && !done_q &&
              ((phase == PH_ONES) || (phase == PH_TENS));
    done_d  = (phase != prev_phase_q) ? 1'b0 : (done_q | capture);

    illegal_entry = (phase == PH_ILLEGAL) && (prev_phase_q != PH_ILLEGAL);

    lit    = ~pat_s2_q;
    dec_ok = 1'b1;
    case (lit)
      7'h3F, 7'h00: dec_digit = 4'd0;
      7'h06:        dec_digit = 4'd1;
      7'h5B:        dec_digit = 4'd2;
      7'h4F:        dec_digit = 4'd3;
      7'h66:        dec_digit = 4'd4;
      7'h6D:        dec_digit = 4'd5;
      7'h7D:        dec_digit = 4'd6;
      7'h07:        dec_digit = 4'd7;
      7'h7F:        dec_digit = 4'd8;
      7'h6F:        dec_digit = 4'd9;
      default: begin
        dec_digit = 4'd0;
        dec_ok    = 1'b0;
      end
    endcase

    state_d  = state_q;
    tmp_d    = tmp_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
    value_d  = value_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    err_d    = illegal_entry;
    tout_d   = tout_q;
    emit     = 1'b0;
    new_ones = (phase == PH_ONES) ? dec_digit : tmp_q;
    new_tens = (phase == PH_TENS) ? dec_digit : tmp_q;

    if (valid_q) begin
      tout_d = tout_q + TCW'(1);
      if (tout_d == TIMEOUT_END)
        valid_d = 1'b0;
    end

    if (capture) begin
      if (!dec_ok) begin
        err_d   = 1'b1;
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            state_d = (phase == PH_ONES) ? ST_HAVE_ONES : ST_HAVE_TENS;
            tmp_d   = dec_digit;
          end
          ST_HAVE_ONES: begin
            if (phase == PH_ONES) tmp_d = dec_digit;
            else                  emit  = 1'b1;
          end
          ST_HAVE_TENS: begin
            if (phase == PH_TENS) tmp_d = dec_digit;
            else                  emit  = 1'b1;
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    if (emit) begin
      state_d  = ST_EMPTY;
      ones_d   = new_ones;
      tens_d   = new_tens;
      value_d  = ({3'b000, new_tens} * 7'd10) + {3'b000, new_ones};
      strobe_d = 1'b1;
      valid_d  = 1'b1;
      tout_d   = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      // Sync stages idle as "all digits off, all segments dark".
      seg_s1_q     <= 4'hF;
      seg_s2_q     <= 4'hF;
      pat_s1_q     <= 7'h7F;
      pat_s2_q     <= 7'h7F;
      prev_phase_q <= PH_GAP;
      prev_pat_q   <= 7'h7F;
      stab_cnt_q   <= '0;
      done_q       <= 1'b0;
      state_q      <= ST_EMPTY;
      tmp_q        <= 4'd0;
      ones_q       <= 4'd0;
      tens_q       <= 4'd0;
      value_q      <= 7'd0;
      valid_q      <= 1'b0;
      strobe_q     <= 1'b0;
      err_q        <= 1'b0;
      tout_q       <= '0;
    end else begin
      seg_s1_q     <= seg_s1_d;
      seg_s2_q     <= seg_s2_d;
      pat_s1_q     <= pat_s1_d;
      pat_s2_q     <= pat_s2_d;
      prev_phase_q <= prev_phase_d;
      prev_pat_q   <= prev_pat_d;
      stab_cnt_q   <= stab_cnt_d;
      done_q       <= done_d;
      state_q      <= state_d;
      tmp_q        <= tmp_d;
      ones_q       <= ones_d;
      tens_q       <= tens_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      strobe_q     <= strobe_d;
      err_q        <= err_d;
      tout_q       <= tout_d;
    end
  end

  assign ones         = ones_q;
  assign tens         = tens_q;
  assign value        = value_q;
  assign valid        = valid_q;
  assign frame_strobe = strobe_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_seven_seg_scan_decoder
// Desc   : Self-checking bench: vector table, corner sequences, random scans
//          against a run-length based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_decoder;

  localparam int STABLE  = 16;
  localparam int TIMEOUT = 4096;
  localparam logic [3:0] S_ONES = 4'b1110;
  localparam logic [3:0] S_TENS = 4'b1101;
  localparam logic [3:0] S_GAP  = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] seg_in = 4'hF;
  logic [7:0] segs_in = 8'hFF;
  logic [3:0] ones, tens;
  logic [6:0] value;
  logic       valid, frame_strobe, err;

  seven_seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .sys_clk(clk), .sys_rst(rst), .seg(seg_in), .segments(segs_in),
    .ones(ones), .tens(tens), .value(value), .valid(valid),
    .frame_strobe(frame_strobe), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] tens_lit;
    logic [6:0] ones_lit;
    int         exp_val;
  } vec_t;

  logic [6:0] lit_tab [10];
  int n_cmp = 0;
  int n_bad = 0;

  // Observation side
  int         cyc = 0;
  int         err_seen = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] obs_q[$];
  int         obs_val[$];
  int         obs_cyc[$];
  int         fall_q[$];
  int         obs_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_strobe) begin
        obs_q.push_back({tens, ones});
        obs_val.push_back(int'(value));
        obs_cyc.push_back(cyc);
      end
      if (err) err_seen++;
      if (valid_prev && !valid) fall_q.push_back(cyc);
    end
    valid_prev = valid;
  end

  // Reference model: works on runs of identical input samples per phase visit
  int         m_last_cls = 0;
  logic [6:0] m_last_lit = 7'h00;
  int         m_run = 0;
  bit         m_done = 0;
  int         m_pend = 0;
  int         m_pdig = 0;
  logic [7:0] exp_q[$];
  int         exp_err = 0;

  function automatic int cls_of(input logic [3:0] s);
    if (s == S_GAP)  return 0;
    if (s == S_ONES) return 1;
    if (s == S_TENS) return 2;
    return 3;
  endfunction

  function automatic int digit_of(input logic [6:0] lit);
    if (lit == 7'h00) return 0;
    for (int i = 0; i < 10; i++)
      if (lit_tab[i] == lit) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_last_cls = 0; m_last_lit = 7'h00; m_run = 0; m_done = 0; m_pend = 0; m_pdig = 0;
  endtask

  task automatic model_step(input logic [3:0] s, input logic [6:0] lit);
    int c;
    int d;
    int t;
    int o;
    c = cls_of(s);
    if (c != m_last_cls) m_done = 0;
    if (c == m_last_cls && lit == m_last_lit) m_run++;
    else m_run = 1;
    if (c == 3 && m_last_cls != 3) exp_err++;
    if ((c == 1 || c == 2) && m_run == STABLE + 1 && !m_done) begin
      m_done = 1;
      d = digit_of(lit);
      if (d < 0) begin
        exp_err++;
        m_pend = 0;
      end else if (m_pend == 0 || m_pend == c) begin
        m_pend = c;
        m_pdig = d;
      end else begin
        t = (c == 2) ? d : m_pdig;
        o = (c == 1) ? d : m_pdig;
        exp_q.push_back({4'(t), 4'(o)});
        m_pend = 0;
      end
    end
    m_last_cls = c;
    m_last_lit = lit;
  endtask

  task automatic step(input logic [3:0] s, input logic [6:0] lit);
    @(posedge clk);
    #1;
    seg_in  = s;
    segs_in = {1'($urandom_range(0, 1)), ~lit};
    model_step(s, lit);
  endtask

  task automatic hold(input logic [3:0] s, input logic [6:0] lit, input int n);
    for (int i = 0; i < n; i++) step(s, lit);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_frames();
    int e;
    int ev;
    while (obs_rd < obs_q.size()) begin
      if (obs_rd < exp_q.size()) begin
        e  = int'(exp_q[obs_rd]);
        ev = (e / 16) * 10 + (e % 16);
        chk("frame_digits", int'(obs_q[obs_rd]), e);
        chk("frame_value", obs_val[obs_rd], ev);
      end
      obs_rd++;
    end
    chk("frame_count", obs_q.size(), exp_q.size());
    chk("err_count", err_seen, exp_err);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ones"}, int'(ones), 0);
    chk({tag, "_tens"}, int'(tens), 0);
    chk({tag, "_value"}, int'(value), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_strobe"}, int'(frame_strobe), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic scan(input logic [6:0] t_lit, input logic [6:0] o_lit, input int len, input int periods);
    for (int p = 0; p < periods; p++) begin
      hold(S_ONES, o_lit, len);
      hold(S_TENS, t_lit, len);
    end
  endtask

  vec_t vecs [34];

  initial begin
    int k0;
    int t0;
    int e0;
    int f0;
    logic [3:0] rs;
    logic [6:0] rl;
    int r;

    lit_tab[0] = 7'h3F; lit_tab[1] = 7'h06; lit_tab[2] = 7'h5B; lit_tab[3] = 7'h4F;
    lit_tab[4] = 7'h66; lit_tab[5] = 7'h6D; lit_tab[6] = 7'h7D; lit_tab[7] = 7'h07;
    lit_tab[8] = 7'h7F; lit_tab[9] = 7'h6F;

    for (int i = 0; i < 32; i++) begin
      vecs[i].tens_lit = lit_tab[i / 10];
      vecs[i].ones_lit = lit_tab[i % 10];
      vecs[i].exp_val  = i;
    end
    vecs[32].tens_lit = lit_tab[9]; vecs[32].ones_lit = lit_tab[9]; vecs[32].exp_val = 99;
    vecs[33].tens_lit = 7'h00;      vecs[33].ones_lit = lit_tab[7]; vecs[33].exp_val = 7;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    hold(S_GAP, 7'h00, 5);

    // Driver-style scan of 23 with long phases; check strobe latency
    hold(S_ONES, lit_tab[3], 512);
    k0 = obs_q.size();
    step(S_TENS, lit_tab[2]);
    t0 = cyc;
    hold(S_TENS, lit_tab[2], 511);
    chk("scan23_strobe_seen", int'(obs_q.size() > k0), 1);
    if (obs_q.size() > k0) chk("scan23_latency", obs_cyc[k0] - t0, STABLE + 3);
    chk("scan23_ones", int'(ones), 3);
    chk("scan23_tens", int'(tens), 2);
    chk("scan23_value", int'(value), 23);
    chk("scan23_valid", int'(valid), 1);
    chk("scan23_no_err", err_seen, 0);
    check_frames();

    // Vector table: sweep, 99, blanked tens
    foreach (vecs[i]) begin
      scan(vecs[i].tens_lit, vecs[i].ones_lit, 40, 2);
      chk("vec_value", int'(value), vecs[i].exp_val);
      chk("vec_valid", int'(valid), 1);
    end
    check_frames();

    // Glitch inside a ones phase
    hold(S_GAP, 7'h00, 10);
    k0 = obs_q.size();
    hold(S_ONES, lit_tab[3], 40);
    hold(S_ONES, lit_tab[8], 5);
    hold(S_ONES, lit_tab[3], 40);
    hold(S_TENS, lit_tab[2], 40);
    chk("glitch_frames", obs_q.size() - k0, 1);
    chk("glitch_value", int'(value), 23);
    check_frames();

    // Illegal select pattern
    e0 = err_seen;
    hold(4'b1100, lit_tab[1], 20);
    hold(S_GAP, 7'h00, 10);
    chk("illegal_err_once", err_seen - e0, 1);

    // Bad ones pattern while holding tens: must drop back to EMPTY
    e0 = err_seen;
    hold(S_TENS, lit_tab[4], 40);
    hold(S_ONES, 7'h30, 40);
    hold(S_GAP, 7'h00, 10);
    hold(S_ONES, lit_tab[5], 40);
    hold(S_TENS, lit_tab[6], 40);
    chk("badpat_err_once", err_seen - e0, 1);
    chk("badpat_value", int'(value), 65);
    check_frames();

    // Timeout after a frame of 42
    f0 = fall_q.size();
    k0 = obs_q.size();
    hold(S_ONES, lit_tab[2], 40);
    hold(S_TENS, lit_tab[4], 40);
    hold(S_GAP, 7'h00, TIMEOUT + 100);
    chk("timeout_fell", int'(fall_q.size() > f0 && obs_q.size() > k0), 1);
    if (fall_q.size() > f0 && obs_q.size() > k0)
      chk("timeout_cycles", fall_q[f0] - obs_cyc[k0], TIMEOUT);
    chk("timeout_valid", int'(valid), 0);
    chk("timeout_value", int'(value), 42);
    check_frames();

    // Reset while holding a ones digit
    hold(S_ONES, lit_tab[9], 40);
    @(posedge clk);
    #1;
    rst = 1'b1; seg_in = S_GAP; segs_in = 8'hFF;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_zero_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    hold(S_GAP, 7'h00, 5);
    hold(S_TENS, lit_tab[1], 40);
    hold(S_ONES, lit_tab[5], 40);
    chk("midrst_value", int'(value), 15);
    check_frames();

    // Random scans against the reference model
    for (int v = 0; v < 80; v++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      rs = S_ONES;
      else if (r < 80) rs = S_TENS;
      else if (r < 95) rs = S_GAP;
      else             rs = ($urandom_range(0, 1) == 0) ? 4'b1100 : 4'b1011;
      r = $urandom_range(0, 99);
      if (r < 90)      rl = lit_tab[$urandom_range(0, 9)];
      else if (r < 95) rl = 7'h00;
      else             rl = 7'($urandom);
      hold(rs, rl, $urandom_range(4, 50));
    end
    hold(S_GAP, 7'h00, 30);
    check_frames();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
